// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-layer timestep controller.
// Holds the controller state encoding, default layer geometry and timing, and the width of
// the per-sample spike counter.
package snn_pkg;

   localparam int unsigned N_DEF       = 8;   // neurons per layer
   localparam int unsigned IDXW_DEF    = 3;   // neuron index width
   localparam int unsigned T_STEPS_DEF = 16;  // timesteps per sample
   localparam int unsigned TO_CYC_DEF  = 32;  // handshake wait limit in cycles
   localparam int unsigned CNT_W       = 8;   // spike and step counter width

   typedef enum logic [2:0] {
      IDLE,
      INTEG,
      WAIT_INT,
      LI,
      WAIT_LI,
      APPLY,
      DONE
   } state_t;

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary index encoder with a one-hot validity flag.
// Ports:
//   vec       - N-bit input vector, expected one-hot
//   idx       - index of the set bit (OR of indices of all set bits if not one-hot)
//   is_onehot - exactly one bit of vec is set
module onehot_enc #(
   parameter int unsigned N    = 8,
   parameter int unsigned IDXW = 3
) (
   input  logic [N-1:0]    vec,
   output logic [IDXW-1:0] idx,
   output logic            is_onehot
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = idx | IDXW'(i);
         end
      end
   end

   assign is_onehot = ($countones(vec) == 1);

endmodule

// File: rtl/snn_step_ctrl.sv
// Timestep sequencer for one spiking-neuron layer and its winner-take-all unit.
// Accepts a sample, then for each of T_STEPS timesteps: starts integration, waits for it,
// starts the WTA compare, waits for it, and applies inhibition plus a learn pulse on a spike.
// At the end of the sample it reports the first winner and the number of spiking timesteps.
// Optional build macro SNN_EARLY_STOP_EN: end the sample right after the first spike.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   sample_valid/sample_ready - sample handshake from the encoder/FIFO
//   integ_start/integ_done    - neuron array integration pulses
//   start_li/valid_li         - WTA compare pulses
//   won_lost, first_spike     - WTA result, latched on valid_li
//   pot_clear                 - per-neuron potential reset (losers on a spike)
//   learn_en, learn_idx       - STDP learn pulse and winner index
//   result_*                  - per-sample result, valid with result_valid
//   timeout_err               - sticky timeout / protocol error flag
module snn_step_ctrl
   import snn_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned IDXW    = IDXW_DEF,
   parameter int unsigned T_STEPS = T_STEPS_DEF,
   parameter int unsigned TO_CYC  = TO_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_valid,
   output logic             sample_ready,
   output logic             integ_start,
   input  logic             integ_done,
   output logic             start_li,
   input  logic             valid_li,
   input  logic [N-1:0]     won_lost,
   input  logic             first_spike,
   output logic [N-1:0]     pot_clear,
   output logic             learn_en,
   output logic [IDXW-1:0]  learn_idx,
   output logic             result_valid,
   output logic [IDXW-1:0]  result_winner,
   output logic [CNT_W-1:0] result_spikes,
   output logic             result_none,
   output logic             timeout_err
);

   localparam int unsigned TOW = $clog2(TO_CYC + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic [CNT_W-1:0] spk_q, spk_d;
   logic [TOW-1:0]   to_q, to_d;
   logic             fs_q, fs_d;
   logic [N-1:0]     wl_q, wl_d;
   logic [IDXW-1:0]  win_q, win_d;
   logic             err_q, err_d;

   logic [IDXW-1:0]  enc_idx;
   logic             enc_oh;
   logic             ready_c;
   logic             spike;
   logic [CNT_W-1:0] step_inc;

   onehot_enc #(
      .N    (N),
      .IDXW (IDXW)
   ) u_enc (
      .vec       (wl_q),
      .idx       (enc_idx),
      .is_onehot (enc_oh)
   );

   // A spike only counts if the latched winner vector is a legal one-hot.
   assign spike    = fs_q & enc_oh;
   assign step_inc = step_q + 1'b1;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      spk_d   = spk_q;
      to_d    = to_q;
      fs_d    = fs_q;
      wl_d    = wl_q;
      win_d   = win_q;
      err_d   = err_q;

      ready_c       = 1'b0;
      integ_start   = 1'b0;
      start_li      = 1'b0;
      pot_clear     = '0;
      learn_en      = 1'b0;
      learn_idx     = '0;
      result_valid  = 1'b0;
      result_winner = '0;
      result_spikes = '0;
      result_none   = 1'b0;

      unique case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (sample_valid) begin
               step_d  = '0;
               spk_d   = '0;
               win_d   = '0;
               state_d = INTEG;
            end
         end
         INTEG: begin
            integ_start = 1'b1;
            state_d     = WAIT_INT;
         end
         WAIT_INT: begin
            if (integ_done) begin
               state_d = LI;
            end else if (to_q == TOW'(TO_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         LI: begin
            start_li = 1'b1;
            state_d  = WAIT_LI;
         end
         WAIT_LI: begin
            if (valid_li) begin
               fs_d    = first_spike;
               wl_d    = won_lost;
               state_d = APPLY;
            end else if (to_q == TOW'(TO_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         APPLY: begin
            if (spike) begin
               pot_clear = ~wl_q;
               learn_en  = 1'b1;
               learn_idx = enc_idx;
               if (spk_q != {CNT_W{1'b1}}) begin
                  spk_d = spk_q + 1'b1;
               end
               if (spk_q == '0) begin
                  win_d = enc_idx;
               end
            end else if (fs_q) begin
               // Multi-hot or empty winner with first_spike set: protocol error.
               err_d = 1'b1;
            end
            step_d = step_inc;
            if (step_inc == CNT_W'(T_STEPS)) begin
               state_d = DONE;
            end else begin
               state_d = INTEG;
            end
`ifdef SNN_EARLY_STOP_EN
            if (spike) begin
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            result_valid  = 1'b1;
            result_winner = win_q;
            result_spikes = spk_q;
            result_none   = (spk_q == '0);
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Each wait state gets a fresh timeout budget.
      if (state_d != state_q) begin
         to_d = '0;
      end
   end

   // Keep the handshake low while reset is held so every output reads 0 in reset.
   assign sample_ready = ready_c & ~rst;
   assign timeout_err  = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         spk_q   <= '0;
         to_q    <= '0;
         fs_q    <= 1'b0;
         wl_q    <= '0;
         win_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         spk_q   <= spk_d;
         to_q    <= to_d;
         fs_q    <= fs_d;
         wl_q    <= wl_d;
         win_q   <= win_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_snn_step_ctrl.sv
// Self-checking bench for snn_step_ctrl with T_STEPS=4. Behavioural responders play the neuron
// array and the WTA unit; a per-sample model derives the expected pulses and results from the
// timestep plan.
module tb_snn_step_ctrl;

   localparam int N    = 8;
   localparam int IDXW = 3;
   localparam int T    = 4;
   localparam int TO   = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            sample_valid;
   logic            sample_ready;
   logic            integ_start;
   logic            integ_done;
   logic            start_li;
   logic            valid_li;
   logic [N-1:0]    won_lost;
   logic            first_spike;
   logic [N-1:0]    pot_clear;
   logic            learn_en;
   logic [IDXW-1:0] learn_idx;
   logic            result_valid;
   logic [IDXW-1:0] result_winner;
   logic [7:0]      result_spikes;
   logic            result_none;
   logic            timeout_err;

   always #5 clk = ~clk;

   snn_step_ctrl #(
      .N       (N),
      .IDXW    (IDXW),
      .T_STEPS (T),
      .TO_CYC  (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .integ_start   (integ_start),
      .integ_done    (integ_done),
      .start_li      (start_li),
      .valid_li      (valid_li),
      .won_lost      (won_lost),
      .first_spike   (first_spike),
      .pot_clear     (pot_clear),
      .learn_en      (learn_en),
      .learn_idx     (learn_idx),
      .result_valid  (result_valid),
      .result_winner (result_winner),
      .result_spikes (result_spikes),
      .result_none   (result_none),
      .timeout_err   (timeout_err)
   );

   int errors = 0;
   int checks = 0;

   // Timestep plan driven by the WTA responder.
   bit         plan_fs [T];
   logic [7:0] plan_wl [T];
   int         d_int = 0;
   int         d_li = 0;
   int         withhold_step = -1;
   int         li_step = 0;
   bit         m_err = 1'b0;  // model of the sticky error flag

   // Monitor state.
   int         n_integ, n_li, n_res, n_bad_pot;
   int         mon_idx [$];
   logic [7:0] mon_pot [$];
   int         res_winner, res_spikes;
   bit         res_none;

   function automatic int idx_of(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Neuron array: answers integ_start once the controller is waiting.
   initial begin
      integ_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (integ_start && !rst) begin
            @(posedge clk); #1;
            for (int i = 0; i < d_int; i++) begin @(posedge clk); #1; end
            if (!rst) integ_done = 1'b1;
            @(posedge clk); #1;
            integ_done = 1'b0;
         end
      end
   end

   // WTA unit: answers start_li with the planned result, garbage otherwise.
   initial begin
      valid_li    = 1'b0;
      first_spike = 1'b0;
      won_lost    = '0;
      forever begin
         @(posedge clk); #1;
         if (start_li && !rst) begin
            automatic int s = li_step;
            li_step++;
            if (s != withhold_step && s < T) begin
               @(posedge clk); #1;
               for (int i = 0; i < d_li; i++) begin @(posedge clk); #1; end
               if (!rst) begin
                  valid_li    = 1'b1;
                  first_spike = plan_fs[s];
                  won_lost    = plan_wl[s];
               end
               @(posedge clk); #1;
               valid_li    = 1'b0;
               first_spike = 1'($urandom_range(0, 1));
               won_lost    = 8'($urandom);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (integ_start) n_integ++;
         if (start_li) n_li++;
         if (learn_en) begin
            mon_idx.push_back(int'(learn_idx));
            mon_pot.push_back(pot_clear);
         end else if (pot_clear != '0) begin
            n_bad_pot++;
         end
         if (result_valid) begin
            n_res++;
            res_winner = int'(result_winner);
            res_spikes = int'(result_spikes);
            res_none   = result_none;
         end
      end
   end

   task automatic clear_mon();
      n_integ = 0; n_li = 0; n_res = 0; n_bad_pot = 0;
      mon_idx.delete(); mon_pot.delete();
      li_step = 0;
   endtask

   task automatic accept(input string name);
      bit ok = 1'b0;
      sample_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (sample_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: sample_ready never seen, got %0b want 1", name, ok);
      end
   endtask

   // Runs one sample with the current plan and checks it against the model.
   task automatic run_sample(input string name, input int to_step);
      int         exp_steps = 0, exp_sp = 0, exp_win = 0;
      int         exp_idx [$];
      logic [7:0] exp_pot [$];
      bit         done = 1'b0;

      clear_mon();
      withhold_step = to_step;
      accept(name);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if (n_res > 0) begin done = 1'b1; break; end
      end
      repeat (4) @(posedge clk);
      #2;
      withhold_step = -1;

      for (int t = 0; t < T; t++) begin
         exp_steps = t + 1;
         if (t == to_step) begin m_err = 1'b1; break; end
         if (plan_fs[t]) begin
            if ($countones(plan_wl[t]) == 1) begin
               exp_idx.push_back(idx_of(plan_wl[t]));
               exp_pot.push_back(~plan_wl[t]);
               if (exp_sp == 0) exp_win = idx_of(plan_wl[t]);
               if (exp_sp < 255) exp_sp++;
`ifdef SNN_EARLY_STOP_EN
               break;
`endif
            end else begin
               m_err = 1'b1;
            end
         end
      end

      checks++;
      if (done !== 1'b1 || n_res != 1) begin
         errors++;
         $display("FAIL %s result_count: got %0d want 1", name, n_res);
      end
      checks++;
      if (res_winner != exp_win) begin
         errors++;
         $display("FAIL %s result_winner: got %0d want %0d", name, res_winner, exp_win);
      end
      checks++;
      if (res_spikes != exp_sp) begin
         errors++;
         $display("FAIL %s result_spikes: got %0d want %0d", name, res_spikes, exp_sp);
      end
      checks++;
      if (res_none !== (exp_sp == 0)) begin
         errors++;
         $display("FAIL %s result_none: got %0b want %0b", name, res_none, exp_sp == 0);
      end
      checks++;
      if (n_integ != exp_steps || n_li != exp_steps) begin
         errors++;
         $display("FAIL %s pulse_count: got integ=%0d li=%0d want %0d", name, n_integ, n_li,
                  exp_steps);
      end
      checks++;
      if (mon_idx.size() != exp_idx.size() || n_bad_pot != 0) begin
         errors++;
         $display("FAIL %s learn_count: got %0d (stray pot %0d) want %0d", name,
                  mon_idx.size(), n_bad_pot, exp_idx.size());
      end else begin
         foreach (exp_idx[k]) begin
            checks++;
            if (mon_idx[k] != exp_idx[k] || mon_pot[k] !== exp_pot[k]) begin
               errors++;
               $display("FAIL %s learn[%0d]: got idx=%0d pot=%h want idx=%0d pot=%h", name, k,
                        mon_idx[k], mon_pot[k], exp_idx[k], exp_pot[k]);
            end
         end
      end
      checks++;
      if (timeout_err !== m_err || sample_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s end_state: got err=%0b ready=%0b want err=%0b ready=1", name,
                  timeout_err, sample_ready, m_err);
      end
   endtask

   task automatic set_plan(input bit fs0, input logic [7:0] w0, input bit fs1,
                           input logic [7:0] w1, input bit fs2, input logic [7:0] w2,
                           input bit fs3, input logic [7:0] w3);
      plan_fs[0] = fs0; plan_wl[0] = w0;
      plan_fs[1] = fs1; plan_wl[1] = w1;
      plan_fs[2] = fs2; plan_wl[2] = w2;
      plan_fs[3] = fs3; plan_wl[3] = w3;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({sample_ready, integ_start, start_li, pot_clear, learn_en, learn_idx, result_valid,
           result_winner, result_spikes, result_none, timeout_err} !== 29'd0) begin
         errors++;
         $display("FAIL reset outputs: got ready=%0b err=%0b pot=%h want all 0", sample_ready,
                  timeout_err, pot_clear);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_err = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (sample_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset idle_ready: got %0b want 1", sample_ready);
      end
   endtask

   task automatic test_no_spike();
      set_plan(0, 8'h04, 0, 8'h10, 0, 8'h01, 0, 8'h80);
      d_int = 0; d_li = 0;
      run_sample("no_spike", -1);
   endtask

   task automatic test_two_spikes();
      set_plan(0, 8'h00, 1, 8'h04, 0, 8'h04, 1, 8'h04);
      d_int = 1; d_li = 2;
      run_sample("two_spikes", -1);
   endtask

   task automatic test_first_winner();
      set_plan(1, 8'h20, 0, 8'h00, 1, 8'h02, 0, 8'h00);
      d_int = 0; d_li = 1;
      run_sample("first_winner", -1);
   endtask

   task automatic test_timeout();
      set_plan(1, 8'h08, 0, 8'h00, 0, 8'h00, 0, 8'h00);
      d_int = 0; d_li = 0;
      run_sample("timeout", 1);
      // Flag must survive a clean sample.
      set_plan(0, 8'h00, 1, 8'h40, 0, 8'h00, 0, 8'h00);
      run_sample("timeout_sticky", -1);
   endtask

   task automatic test_protocol_err();
      set_plan(1, 8'h11, 1, 8'h02, 1, 8'h00, 0, 8'h00);
      run_sample("protocol_err", -1);
   endtask

   task automatic test_abort();
      bit reached = 1'b0;
      set_plan(0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00);
      d_int = 0; d_li = 6;
      clear_mon();
      accept("abort");
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #2;
         if (n_li == 3) begin reached = 1'b1; break; end
      end
      checks++;
      if (reached !== 1'b1) begin
         errors++;
         $display("FAIL abort reach_step2: got li=%0d want 3", n_li);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({sample_ready, integ_start, start_li, pot_clear, learn_en, learn_idx, result_valid,
           result_winner, result_spikes, result_none, timeout_err} !== 29'd0) begin
         errors++;
         $display("FAIL abort outputs: got ready=%0b err=%0b pot=%h want all 0", sample_ready,
                  timeout_err, pot_clear);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_err = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      checks++;
      if (n_res != 0) begin
         errors++;
         $display("FAIL abort no_result: got %0d want 0", n_res);
      end
      set_plan(1, 8'h01, 0, 8'h00, 1, 8'h80, 0, 8'h00);
      d_li = 0;
      run_sample("after_abort", -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         for (int t = 0; t < T; t++) begin
            plan_fs[t] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) plan_wl[t] = 8'($urandom);
            else plan_wl[t] = 8'h01 << $urandom_range(0, 7);
         end
         d_int = $urandom_range(0, 4);
         d_li  = $urandom_range(0, 4);
         run_sample($sformatf("random%0d", n), -1);
      end
   endtask

   initial begin
      sample_valid = 1'b0;
      rst = 1'b1;
      test_reset();
      test_no_spike();
      test_two_spikes();
      test_first_winner();
      test_timeout();
      test_abort();
      test_protocol_err();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
